// File: rtl/video_pattern_core_pkg.sv
// Shared types and constants for the video pattern source and its helpers.
package video_pattern_core_pkg;

    localparam int RGB_W = 4;
    localparam logic [RGB_W-1:0] CH_MAX = '1;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
        logic             sof;
        logic             eol;
    } vga_frame_t;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_GRAD    = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_mode_e;

    // {r,g,b} on/off per bar; index 0 (rightmost) is white, 7 is black.
    localparam logic [7:0][2:0] BAR_LUT = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    function automatic logic [RGB_W-1:0] ch_level(input logic on);
        return on ? CH_MAX : '0;
    endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Raster position counters (x, y, colour-bar index) stepped by an advance strobe.
module video_raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int BAR_W = 80,
    parameter int XW    = $clog2(H_RES),
    parameter int YW    = $clog2(V_RES),
    parameter int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    bar_idx,
    output logic          line_end,
    output logic          frame_start
);

    localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [BW-1:0] bar_px;

    assign line_end    = (x == X_LAST);
    assign frame_start = (x == '0) && (y == '0);

    // Step the raster; bar counters run alongside x so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (advance) begin
            if (line_end) begin
                x       <= '0;
                bar_px  <= '0;
                bar_idx <= '0;
                y       <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
                if (bar_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_px <= bar_px + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/video_pattern_core.sv
// Stall-aware test-pattern source: one registered pixel per accepted cycle in raster order.
module video_pattern_core
    import video_pattern_core_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BAR_W      = 80,
    parameter int CHK_SHIFT  = 5,
    parameter int GRAD_SHIFT = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [3*RGB_W-1:0] solid_rgb,
    output logic               sink_vld,
    output vga_frame_t         sink_frame
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);

    logic          advance;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    bar_idx;
    logic          line_end;
    logic          frame_start;
    pat_mode_e     mode_q;
    pat_mode_e     eff_mode;
    logic [2:0]    bar_rgb;
    logic          chk_on;
    logic [31:0]   lvl;
    logic [RGB_W-1:0] lvl_sat;
    vga_frame_t    pix;

    assign advance = enable && !stall;

    video_raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .BAR_W (BAR_W),
        .XW    (XW),
        .YW    (YW)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .x           (x),
        .y           (y),
        .bar_idx     (bar_idx),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    // Pixel for the current position; the mode input only counts at frame start.
    always_comb begin
        pix      = '0;
        eff_mode = frame_start ? pat_mode_e'(mode) : mode_q;
        bar_rgb  = BAR_LUT[bar_idx];
        chk_on   = ~(x[CHK_SHIFT] ^ y[CHK_SHIFT]);
        lvl      = 32'(y) >> GRAD_SHIFT;
        lvl_sat  = (lvl > 32'(CH_MAX)) ? CH_MAX : lvl[RGB_W-1:0];
        case (eff_mode)
            PAT_BARS: begin
                pix.r = ch_level(bar_rgb[2]);
                pix.g = ch_level(bar_rgb[1]);
                pix.b = ch_level(bar_rgb[0]);
            end
            PAT_CHECKER: begin
                pix.r = ch_level(chk_on);
                pix.g = ch_level(chk_on);
                pix.b = ch_level(chk_on);
            end
            PAT_GRAD: begin
                pix.r = lvl_sat;
                pix.g = lvl_sat;
                pix.b = lvl_sat;
            end
            PAT_SOLID: {pix.r, pix.g, pix.b} = solid_rgb;
            default: ;
        endcase
        pix.sof = frame_start;
        pix.eol = line_end;
    end

    // Valid and latched mode: frozen under stall, valid drops when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sink_vld <= 1'b0;
            mode_q   <= PAT_BARS;
        end else if (!stall) begin
            sink_vld <= enable;
            if (enable && frame_start)
                mode_q <= pat_mode_e'(mode);
        end
    end

    // Pixel data register; no reset, only meaningful while sink_vld is high.
    always_ff @(posedge clk) begin
        if (advance)
            sink_frame <= pix;
    end

endmodule

// File: tb/tb_video_pattern_core.sv
// Randomized bench for video_pattern_core with a pixel-index reference model.
`timescale 1ns/1ps
module tb_video_pattern_core;
    import video_pattern_core_pkg::*;

    localparam int H  = 64;
    localparam int V  = 480;
    localparam int BW = 8;
    localparam int CS = 5;
    localparam int GS = 5;
    localparam int FRAME = H * V;
    localparam logic [RGB_W-1:0] MX = '1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stall = 1'b0;
    logic               enable = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [3*RGB_W-1:0] solid_rgb = '0;
    logic               sink_vld;
    vga_frame_t         sink_frame;

    video_pattern_core #(
        .H_RES      (H),
        .V_RES      (V),
        .BAR_W      (BW),
        .CHK_SHIFT  (CS),
        .GRAD_SHIFT (GS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .enable     (enable),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .sink_vld   (sink_vld),
        .sink_frame (sink_frame)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vga_frame_t fr(input int r, input int g, input int b, input bit s, input bit e);
        vga_frame_t f;
        f.r = RGB_W'(r);
        f.g = RGB_W'(g);
        f.b = RGB_W'(b);
        f.sof = s;
        f.eol = e;
        return f;
    endfunction

    // What pixel (px,py) must look like under pattern md.
    function automatic vga_frame_t model_pix(input logic [1:0] md, input int px, input int py,
                                             input logic [3*RGB_W-1:0] srgb, input int gs);
        vga_frame_t f;
        int bar;
        int lv;
        bit on;
        f = '0;
        case (md)
            2'd0: begin
                bar = px / BW;
                f.r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? MX : '0;
                f.g = (bar <= 3) ? MX : '0;
                f.b = (bar % 2 == 0) ? MX : '0;
            end
            2'd1: begin
                on = ((((px >> CS) ^ (py >> CS)) & 1) == 0);
                f.r = on ? MX : '0;
                f.g = f.r;
                f.b = f.r;
            end
            2'd2: begin
                lv = py >> gs;
                if (lv > int'(MX)) lv = int'(MX);
                f.r = RGB_W'(lv);
                f.g = f.r;
                f.b = f.r;
            end
            default: {f.r, f.g, f.b} = srgb;
        endcase
        f.sof = (px == 0 && py == 0);
        f.eol = (px == H - 1);
        return f;
    endfunction

    // Reference state: n = pixels generated since reset.
    int         n = 0;
    int         mx, my;
    logic [1:0] fmode = 2'd0;
    logic       m_vld = 1'b0;
    vga_frame_t m_frm = '0;
    logic       gen, st_s;
    vga_frame_t cap [int];
    int         dut_pix = 0;
    int         dut_sof = 0;
    int         gap_vld = 0;
    logic       gap_win = 1'b0;

    always @(posedge clk) begin
        gen  = 1'b0;
        st_s = stall;
        if (rst) begin
            m_vld = 1'b0;
            n     = 0;
            fmode = 2'd0;
        end else if (!stall) begin
            if (enable) begin
                mx = n % H;
                my = (n / H) % V;
                if (mx == 0 && my == 0) fmode = mode;
                m_frm = model_pix(fmode, mx, my, solid_rgb, GS);
                m_vld = 1'b1;
                n++;
                gen = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
        #1;
        check("sink_vld", 32'(sink_vld), 32'(m_vld));
        if (m_vld) check("sink_frame", 32'(sink_frame), 32'(m_frm));
        if (rst) begin
            cap.delete();
            dut_pix = 0;
            dut_sof = 0;
        end else begin
            if (gen) cap[n-1] = sink_frame;
            if (!st_s && sink_vld) begin
                dut_pix++;
                if (sink_frame.sof) dut_sof++;
            end
        end
        if (gap_win && sink_vld) gap_vld++;
    end

    int  cyc;
    int  stall_left;
    bit  did_stall;

    initial begin
        // Pin the model against hand-computed pixels.
        check("pin_bar0",   32'(model_pix(2'd0, 0, 0, '0, GS)),   32'(fr(15, 15, 15, 1, 0)));
        check("pin_bar1",   32'(model_pix(2'd0, 8, 0, '0, GS)),   32'(fr(15, 15, 0, 0, 0)));
        check("pin_chk",    32'(model_pix(2'd1, 32, 0, '0, GS)),  32'(fr(0, 0, 0, 0, 0)));
        check("pin_grad5",  32'(model_pix(2'd2, 0, 479, '0, 5)),  32'(fr(14, 14, 14, 1'b0, 0)));
        check("pin_grad4",  32'(model_pix(2'd2, 63, 479, '0, 4)), 32'(fr(15, 15, 15, 0, 1)));

        // Reset, then bars with a mode switch to checker inside frame 0.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        mode   = 2'd0;
        @(posedge clk);
        #2;
        check("first_vld", 32'(sink_vld), 32'd1);

        cyc = 0; stall_left = 0; did_stall = 0;
        while (n < FRAME + 32 * H + 33 && cyc < 50000) begin
            @(negedge clk);
            cyc++;
            solid_rgb = (3*RGB_W)'($urandom);
            if (n >= 300) mode = 2'd1;
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else if (n == 100 && !did_stall) begin
                did_stall  = 1;
                stall      = 1'b1;
                stall_left = 4;
            end else begin
                stall = (n > 100) && ($urandom_range(0, 9) == 0);
            end
        end
        check("p1_progress", 32'(n >= FRAME + 32 * H + 33), 32'd1);
        check("px0",     32'(cap[0]),     32'(fr(15, 15, 15, 1, 0)));
        check("px8",     32'(cap[8]),     32'(fr(15, 15, 0, 0, 0)));
        check("px55",    32'(cap[55]),    32'(fr(0, 0, 15, 0, 0)));
        check("px63",    32'(cap[63]),    32'(fr(0, 0, 0, 0, 1)));
        check("px64",    32'(cap[64]),    32'(fr(15, 15, 15, 0, 0)));
        check("px100",   32'(cap[100]),   32'(fr(15, 0, 15, 0, 0)));
        check("px310",   32'(cap[310]),   32'(fr(0, 0, 15, 0, 0)));
        check("f0_last", 32'(cap[FRAME-1]), 32'(fr(0, 0, 0, 0, 1)));
        check("f1_0_0",  32'(cap[FRAME]),   32'(fr(15, 15, 15, 1, 0)));
        check("f1_32_0", 32'(cap[FRAME+32]), 32'(fr(0, 0, 0, 0, 0)));
        check("f1_32_32", 32'(cap[FRAME+32*H+32]), 32'(fr(15, 15, 15, 0, 0)));

        // Run unstalled to (20,33) of frame 1, then reset mid-frame.
        stall = 1'b0;
        cyc = 0;
        while (n < FRAME + 33 * H + 20 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
            check("rst_vld", 32'(sink_vld), 32'd0);
        end
        @(negedge clk);
        rst  = 1'b0;
        mode = 2'd2;

        // Gradient frame with random stalls, solid colour queued for the next frame.
        cyc = 0;
        while (n < FRAME + 600 && cyc < 50000) begin
            @(negedge clk);
            cyc++;
            solid_rgb = (3*RGB_W)'($urandom);
            stall = ($urandom_range(0, 9) == 0);
            if (n >= 15000) mode = 2'd3;
        end
        check("p3_progress", 32'(n), 32'(FRAME + 600));
        check("g_first",  32'(cap[0]),       32'(fr(0, 0, 0, 1, 0)));
        check("g_line31", 32'(cap[31*H]),    32'(fr(0, 0, 0, 0, 0)));
        check("g_line32", 32'(cap[32*H]),    32'(fr(1, 1, 1, 0, 0)));
        check("g_line479", 32'(cap[479*H]),  32'(fr(14, 14, 14, 0, 0)));
        check("g_last",   32'(cap[FRAME-1]), 32'(fr(14, 14, 14, 0, 1)));
        check("s_sof",    32'(cap[FRAME].sof), 32'd1);

        // Enable toggled every cycle: valid every other cycle, order unbroken.
        stall   = 1'b0;
        gap_vld = 0;
        gap_win = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            enable    = (i % 2 == 0);
            solid_rgb = (3*RGB_W)'($urandom);
            @(negedge clk);
        end
        gap_win = 1'b0;
        check("gap_vld",   32'(gap_vld), 32'd500);
        check("pix_count", 32'(dut_pix), 32'(FRAME + 1100));
        check("sof_count", 32'(dut_sof), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
